// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared types and sizing helpers for the DRAM arbiter.
//   state_e   - arbiter FSM states
//   owner_e   - current / last bus owner
//   cnt_width - width of the shared gap/timeout down-counter
package dram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_CYC,
    ST_CPU_END,
    ST_DMA_CYC,
    ST_DMA_END,
    ST_GAP
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  function automatic int unsigned cnt_width(input int unsigned gap, input int unsigned timeout);
    int unsigned m;
    m = (gap > timeout) ? gap : timeout;
    return $clog2(m) + 1;
  endfunction

  localparam int unsigned CNT_W_DEFAULT = cnt_width(2, 64);

endpackage

// File: rtl/dram_arb_timer.sv
// dram_arb_timer: loadable down-counter shared by the precharge gap and
// the DTACK timeout watchdog.
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - load load_val (has priority over en)
//   load_val   - value to load
//   en         - decrement by one, saturating at zero
//   zero       - count is zero
module dram_arb_timer #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one dram_controller between the 68000 bus and a DMA
// requester. Round-robin grant, RAS precharge gap, DTACK timeout watchdog.
//   CLK, RST                    - clock, asynchronous active-low reset
//   CPU_CS/AS/UDS/LDS/RW/ADDR   - 68000 side request (strobes active-low)
//   CPU_DTACK, CPU_BERR         - 68000 termination (active-low)
//   DMA_REQ/ADDR/BE/WE          - DMA request (level, held until DMA_ACK)
//   DMA_ACK, DMA_ERR            - one-cycle completion / timeout flag
//   MEM_CS/AS/UDS/LDS/RW/ADDR   - to dram_controller bus-side inputs
//   MEM_DTACK                   - from dram_controller (active-low)
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CPU_CS,
  input  logic        CPU_AS,
  input  logic        CPU_UDS,
  input  logic        CPU_LDS,
  input  logic        CPU_RW,
  input  logic [22:0] CPU_ADDR,
  output logic        CPU_DTACK,
  output logic        CPU_BERR,
  input  logic        DMA_REQ,
  input  logic [22:0] DMA_ADDR,
  input  logic [1:0]  DMA_BE,
  input  logic        DMA_WE,
  output logic        DMA_ACK,
  output logic        DMA_ERR,
  output logic        MEM_CS,
  output logic        MEM_AS,
  output logic        MEM_UDS,
  output logic        MEM_LDS,
  output logic        MEM_RW,
  output logic [22:0] MEM_ADDR,
  input  logic        MEM_DTACK
);

  localparam int unsigned CNT_W = cnt_width(GAP_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic               err_q, err_d;
  logic               tmr_load, tmr_en, tmr_zero;
  logic [CNT_W-1:0]   tmr_val;
  logic               cpu_req, dtack;

  assign cpu_req = !CPU_CS && !CPU_AS;
  assign dtack   = !MEM_DTACK;

  dram_arb_timer #(.W(CNT_W)) u_timer (
    .clk      (CLK),
    .rst_n    (RST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // Next state. The timer is loaded with N-1 on entry so that zero marks
  // the last of N cycles; DTACK is tested before the timeout so it wins a tie.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = TO_LOAD;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && (!DMA_REQ || (owner_q == OWN_DMA))) begin
          state_d  = ST_CPU_CYC;
          owner_d  = OWN_CPU;
          err_d    = 1'b0;
          tmr_load = 1'b1;
        end else if (DMA_REQ) begin
          state_d  = ST_DMA_CYC;
          owner_d  = OWN_DMA;
          err_d    = 1'b0;
          tmr_load = 1'b1;
        end
      end
      ST_CPU_CYC: begin
        tmr_en = 1'b1;
        if (dtack) begin
          state_d = ST_CPU_END;
        end else if (CPU_AS) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end else if (tmr_zero) begin
          state_d = ST_CPU_END;
          err_d   = 1'b1;
        end
      end
      ST_CPU_END: begin
        if (CPU_AS) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end
      end
      ST_DMA_CYC: begin
        tmr_en = 1'b1;
        if (dtack) begin
          state_d = ST_DMA_END;
        end else if (tmr_zero) begin
          state_d = ST_DMA_END;
          err_d   = 1'b1;
        end
      end
      ST_DMA_END: begin
        state_d  = ST_GAP;
        tmr_load = 1'b1;
        tmr_val  = GAP_LOAD;
      end
      ST_GAP: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_DMA;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  // Outputs. In CPU_END the termination is gated by CPU_AS so it releases
  // in the same cycle MEM_AS (which follows CPU_AS) rises.
  always_comb begin
    MEM_AS    = 1'b1;
    MEM_UDS   = 1'b1;
    MEM_LDS   = 1'b1;
    MEM_RW    = 1'b1;
    CPU_DTACK = 1'b1;
    CPU_BERR  = 1'b1;
    DMA_ACK   = 1'b0;
    DMA_ERR   = 1'b0;
    case (state_q)
      ST_CPU_CYC: begin
        MEM_AS    = CPU_AS;
        MEM_UDS   = CPU_UDS;
        MEM_LDS   = CPU_LDS;
        MEM_RW    = CPU_RW;
        CPU_DTACK = MEM_DTACK;
      end
      ST_CPU_END: begin
        MEM_AS    = CPU_AS;
        MEM_UDS   = CPU_UDS;
        MEM_LDS   = CPU_LDS;
        MEM_RW    = CPU_RW;
        CPU_DTACK = CPU_AS || err_q;
        CPU_BERR  = CPU_AS || !err_q;
      end
      ST_DMA_CYC, ST_DMA_END: begin
        MEM_AS  = 1'b0;
        MEM_UDS = !DMA_BE[1];
        MEM_LDS = !DMA_BE[0];
        MEM_RW  = !DMA_WE;
        if (state_q == ST_DMA_END) begin
          DMA_ACK = 1'b1;
          DMA_ERR = err_q;
        end
      end
      default: ;
    endcase
  end

  assign MEM_CS   = MEM_AS;
  assign MEM_ADDR = (owner_q == OWN_DMA) ? DMA_ADDR : CPU_ADDR;

endmodule
